// File: rtl/muldiv_unit_if.sv
// Request/response bundle between a pipeline and the multiply/divide unit.
// Latency: none, signal grouping only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, op, a, b   request (op is the RV-M funct3 encoding)
//   in_ready             unit can take a request
//   kill                 pipeline flush, aborts whatever the unit is doing
//   out_valid, result    response, result reads zero while out_valid is low
//   out_ready            consumer takes the response
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    // Pipeline side: issues requests and consumes results.
    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result
    );

    // Unit side.
    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide unit (shift-add multiplier, restoring radix-2 divider).
// Latency: WIDTH+1 cycles from acceptance for iterative ops, 1 cycle for divide-by-zero, signed overflow and (optionally) multiplies.
// Backpressure: in_ready only while idle; the result is held in DONE until out_ready, kill flushes at any time.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     muldiv_unit_if.slave: in_valid/in_ready/op/a/b request, kill flush,
//           out_valid/out_ready/result response
//
// Build option: define MULDIV_SINGLE_CYCLE_MUL_EN to replace the shift-add
// multiplier with a combinational 2*WIDTH-bit product; the MUL state is then
// never entered. The divider is the same in both builds.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    localparam int                CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(WIDTH);
    localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Shared datapath registers.
    //   multiply: {acc_hi, acc_lo} is the product/multiplier shift pair, opnd = |a|
    //   divide:   acc_hi is the partial remainder, acc_lo dividend->quotient, opnd = |b|
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [2:0]       op_q;
    logic             neg_q;     // negate product / quotient in the finishing step
    logic             neg_r;     // negate remainder in the finishing step
    logic [WIDTH-1:0] res_q;

    // ------------------------------------------------------------------
    // Request decode, evaluated on the raw inputs at acceptance
    // ------------------------------------------------------------------
    logic             accept;
    logic             req_div;
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             short_path;
    state_t           req_state;

    assign accept  = bus.in_valid & (state == IDLE) & ~bus.kill;
    assign req_div = bus.op[2];

    // Divide: DIV/REM signed, DIVU/REMU unsigned.
    // Multiply: MULH signs both, MULHSU signs a only; MUL/MULHU treat both as
    // unsigned (the low half of the product does not depend on signedness).
    assign a_sgn = req_div ? ~bus.op[0] : (bus.op[0] ^ bus.op[1]);
    assign b_sgn = req_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
    assign a_neg = a_sgn & bus.a[WIDTH-1];
    assign b_neg = b_sgn & bus.b[WIDTH-1];
    // The most negative value maps onto itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    assign div_zero = req_div & (bus.b == '0);
    assign div_ovf  = req_div & ~bus.op[0] & (bus.a == MOST_NEG) & (&bus.b);

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    // Low 2*WIDTH bits of the product only depend on the low 2*WIDTH bits of
    // the sign-extended operands, so an unsigned 2*WIDTH multiply suffices.
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_fast;

    assign a_ext      = {{WIDTH{a_sgn & bus.a[WIDTH-1]}}, bus.a};
    assign b_ext      = {{WIDTH{b_sgn & bus.b[WIDTH-1]}}, bus.b};
    assign prod_fast  = a_ext * b_ext;
    assign short_path = div_zero | div_ovf | ~req_div;
`else
    assign short_path = div_zero | div_ovf;
`endif

    // Short-path operations park in DIV with the counter already at WIDTH, so
    // the very next edge runs only the finishing step and enters DONE.
    assign req_state = (req_div | short_path) ? DIV : MUL;

    // ------------------------------------------------------------------
    // One iteration step of each engine
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    // When div_ge holds the true difference is below 2^WIDTH, so the
    // truncated subtraction is exact.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    // ------------------------------------------------------------------
    // Finishing step: sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_res;

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -acc_lo : acc_lo;
    assign rem_s  = neg_r ? -acc_hi : acc_hi;

    always_comb begin
        fix_res = '0;
        if (!op_q[2]) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end else begin
            fix_res = op_q[1] ? rem_s : quo_s;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = req_state;
            MUL:  if (cnt == CNT_LAST) state_nxt = DONE;
            DIV:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Flush wins over everything, including a same-cycle acceptance.
        if (bus.kill) begin
            state_nxt = IDLE;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = (state == DONE) ? res_q : '0;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            res_q  <= '0;
        end else if (bus.kill) begin
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.op;
                        cnt    <= '0;
                        acc_hi <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (req_div) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end
                        // Short paths preload the final quotient/remainder
                        // (or product) with no sign correction pending.
                        if (div_zero) begin
                            acc_lo <= '1;
                            acc_hi <= bus.a;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            cnt    <= CNT_LAST;
                        end else if (div_ovf) begin
                            acc_lo <= bus.a;
                            acc_hi <= '0;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            cnt    <= CNT_LAST;
                        end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                        else if (!req_div) begin
                            {acc_hi, acc_lo} <= prod_fast;
                            neg_q            <= 1'b0;
                            neg_r            <= 1'b0;
                            cnt              <= CNT_LAST;
                        end
`endif
                    end
                end
                MUL: begin
                    if (cnt != CNT_LAST) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        cnt    <= cnt + CW'(1);
                    end else begin
                        res_q <= fix_res;
                    end
                end
                DIV: begin
                    if (cnt != CNT_LAST) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        cnt    <= cnt + CW'(1);
                    end else begin
                        res_q <= fix_res;
                    end
                end
                DONE: begin
                    // result held until the consumer takes it
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model, latency, hold, kill, reset.
// Latency expectations follow the MULDIV_SINGLE_CYCLE_MUL_EN build option.
// A compare process checks result against the model on every valid cycle.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_res = '0;
    bit          exp_live = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lit;
        bit          has_lit;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [31:0]     r;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Edges from acceptance to out_valid.
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return W + 1;
        end
        return FAST_MUL ? 1 : W + 1;
    endfunction

    // Compare process: result vs model whenever valid, zero otherwise.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (!exp_live) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            else check("result_vs_model", bus.result, exp_res);
        end else begin
            check("result_zero_when_invalid", bus.result, 32'd0);
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 idle.
    task automatic run_op(input vec_t v);
        int n;
        check("in_ready_before_req", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = v.op;
        bus.a        = v.a;
        bus.b        = v.b;
        exp_res      = model(v.op, v.a, v.b);
        exp_live     = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the operation must not notice.
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(model_lat(v.op, v.a, v.b)));
        if (v.has_lit) check("literal_result", bus.result, v.lit);
        if (v.hold > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                check("hold_out_valid", 32'(bus.out_valid), 32'd1);
                check("hold_result", bus.result, exp_res);
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        exp_live = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        bit  fired;

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b1;

        //             op      a              b              lit            has hold
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1, 0});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{3'd7, 32'd100,       32'd0,         32'd100,       1, 0});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 5});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1, 0});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 1, 0});
        vecs.push_back('{3'd7, 32'd17,        32'd5,         32'd2,         1, 0});
        vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0});
        vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1, 0});
        vecs.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 0});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 1, 0});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 1, 0});
        vecs.push_back('{3'd5, 32'd0,         32'd5,         32'd0,         1, 0});
        vecs.push_back('{3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         0, 0});
        vecs.push_back('{3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         0, 2});

        // Reset state.
        #3;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // First request lands on the first edge after reset release.
        foreach (vecs[i]) run_op(vecs[i]);

        // Kill at iteration 10 of DIVU: nothing may come out.
        bus.in_valid = 1'b1;
        bus.op       = 3'd5;
        bus.a        = 32'd1000;
        bus.b        = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_in_ready", 32'(bus.in_ready), 32'd1);
        check("kill_out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("kill_never_valid", 32'(seen), 32'd0);

        // Kill together with a request: acceptance is discarded.
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        bus.op       = 3'd5;
        bus.a        = 32'd5;
        bus.b        = 32'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        check("kill_accept_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("kill_accept_out_valid", 32'(bus.out_valid), 32'd0);

        // Kill while a result waits in DONE.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd5;
        bus.a         = 32'd9;
        bus.b         = 32'd0;
        exp_res       = model(3'd5, 32'd9, 32'd0);
        exp_live      = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("done_before_kill", 32'(bus.out_valid), 32'd1);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        exp_live = 1'b0;
        check("done_kill_out_valid", 32'(bus.out_valid), 32'd0);
        check("done_kill_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset pulsed in the middle of a multiply.
        bus.in_valid = 1'b1;
        bus.op       = 3'd3;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        exp_res      = model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_live     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        exp_live = 1'b0;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        fired = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) fired = 1'b1;
        end
        check("rst_no_late_result", 32'(fired), 32'd0);

        // Short reset, then a request on the first edge after release.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 0});

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: op  input  3  RV-M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port: a  input  WIDTH  rs1 operand.
REQ-008 SHALL have port: b  input  WIDTH  rs2 operand.
REQ-009 SHALL have port: kill  input  1  pipeline flush; abort current operation.
REQ-010 SHALL have port: out_valid  output  1  result present.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port: result  output  WIDTH  operation result.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-014 in_ready SHALL be high only in IDLE; a request SHALL be accepted on a rising edge with in_valid and in_ready both high, and op, a and b SHALL be latched there.
REQ-015 Iterative MUL/DIV SHALL run WIDTH iteration cycles, then one sign-fixup cycle; out_valid SHALL go high after edge k+WIDTH+1 for acceptance at edge k.
REQ-016 The multiplier SHALL form the full 2*WIDTH-bit product: MUL returns the low half; MULH signed x signed, MULHSU signed a x unsigned b and MULHU unsigned x unsigned return the high half.
REQ-017 The divider SHALL be restoring radix-2 on magnitudes: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) for DIV/REM, unsigned for DIVU/REMU.
REQ-018 Divide by zero SHALL skip iteration and enter DONE after edge k+1: quotient = all ones, remainder = a.
REQ-019 Signed overflow (a = most negative, b = -1, op DIV/REM) SHALL skip iteration and enter DONE after edge k+1: quotient = a, remainder = 0.
REQ-020 In DONE, out_valid and result SHALL hold stable until a rising edge with out_ready high; the unit SHALL then go to IDLE.
REQ-021 kill SHALL have priority over all other inputs and act synchronously: the next edge goes to IDLE, clears out_valid and discards any acceptance in the same cycle.
REQ-022 result SHALL be zero whenever out_valid is low.
REQ-023 Input changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-024 While rst_n is low, the unit SHALL immediately go to IDLE with out_valid=0, result=0, in_ready=1 and all internal counters and accumulators at 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation, with no result delivered after release.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro MULDIV_SINGLE_CYCLE_MUL_EN, when defined, SHALL replace the iterative multiplier with a combinational 2*WIDTH-bit product: all MUL* ops enter DONE after edge k+1, and the MUL state is unused.
REQ-028 Without MULDIV_SINGLE_CYCLE_MUL_EN, MUL* ops SHALL use the shift-add iteration with the REQ-015 latency.
REQ-029 The divider SHALL be identical in both builds.

Verification
REQ-030 The bench SHALL cover: WIDTH=32, DIV a=-7 b=2 -> result 0xFFFFFFFD (-3) at edge k+33; REM same operands -> 0xFFFFFFFF (-1).
REQ-031 The bench SHALL cover: DIVU a=100 b=0 -> 0xFFFFFFFF at edge k+1; REMU same operands -> 100.
REQ-032 The bench SHALL cover: DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0, both at edge k+1.
REQ-033 The bench SHALL cover: MULH a=0x80000000 b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1 b=2 -> 0xFFFFFFFF; latency checked in both macro builds.
REQ-034 The bench SHALL cover: out_ready held low 5 cycles in DONE -> result stable and in_ready low; out_ready high -> IDLE on the next edge.
REQ-035 The bench SHALL cover: kill at iteration 10 of DIVU -> out_valid never rises and in_ready=1 next cycle; rst_n pulsed mid-MUL -> out_valid=0 and result=0 immediately.
